// File: rtl/axis_arb_mux_monitor_pkg.sv
// Shared error-bit indices and grant-state encoding for the AXI-stream arbitrating mux monitor.
package axis_mon_pkg;

  localparam int unsigned ERR_W       = 6;
  localparam int unsigned ERR_ONEHOT  = 0;
  localparam int unsigned ERR_SWITCH  = 1;
  localparam int unsigned ERR_DATA    = 2;
  localparam int unsigned ERR_ORDER   = 3;
  localparam int unsigned ERR_OVERFLOW = 4;
  localparam int unsigned ERR_TIMEOUT = 5;

  typedef enum logic {
    IDLE,
    LOCKED
  } mon_state_t;

endpackage

// File: rtl/axis_arb_mux_monitor_if.sv
// Slave-side and master-side AXI-stream signals of the observed mux, bundled for the monitor.
interface axis_arb_mux_monitor_if #(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1
);

  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
  logic [S_COUNT-1:0]            s_axis_tvalid;
  logic [S_COUNT-1:0]            s_axis_tready;
  logic [S_COUNT-1:0]            s_axis_tlast;
  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;
  logic [USER_WIDTH-1:0]         m_axis_tuser;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser,
    output m_axis_tdata, m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser
  );

  modport slave (
    input s_axis_tdata, s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser,
    input m_axis_tdata, m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser
  );

endinterface

// File: rtl/axis_arb_mux_monitor_sb_fifo.sv
// Synchronous scoreboard FIFO; push at full is dropped unless a pop frees the slot in the same cycle.
module axis_mon_sb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     full_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full_c  = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full_c | do_pop);
  assign rdata_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/axis_arb_mux_monitor.sv
// Passive checker beside an AXI-stream arbitrating mux: grant atomicity, one-hot ready,
// in-order data integrity, starvation watchdogs, sticky error flags and per-input packet counts.
module axis_arb_mux_monitor
  import axis_mon_pkg::*;
#(
  parameter int unsigned S_COUNT     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned USER_ENABLE = 1,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned SB_DEPTH    = 8,
  parameter int unsigned TIMEOUT     = 32,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  axis_arb_mux_monitor_if.slave          bus,
  input  logic                           err_clear,
  output logic [ERR_W-1:0]               err_flags,
  output logic [$clog2(S_COUNT)-1:0]     err_chan,
  output logic [S_COUNT*CNT_WIDTH-1:0]   pkt_count
);

  localparam int unsigned CH_W  = $clog2(S_COUNT);
  localparam int unsigned PAY_W = USER_WIDTH + 1 + DATA_WIDTH;
  localparam int unsigned ENT_W = CH_W + PAY_W;

  logic [S_COUNT-1:0]    s_acc;
  logic                  m_acc;
  logic                  any_acc;
  logic [CH_W-1:0]       sel;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  sel_last;
  logic [CH_W-1:0]       rdy_low;
  logic [USER_WIDTH-1:0] user_mask;

  assign s_acc     = bus.s_axis_tvalid & bus.s_axis_tready;
  assign m_acc     = bus.m_axis_tvalid & bus.m_axis_tready;
  assign user_mask = (USER_ENABLE != 0) ? '1 : '0;

  // Lowest-index accepted beat is the one the scoreboard tracks.
  always_comb begin
    any_acc  = 1'b0;
    sel      = '0;
    sel_data = '0;
    sel_user = '0;
    sel_last = 1'b0;
    rdy_low  = '0;
    for (int i = int'(S_COUNT) - 1; i >= 0; i--) begin
      if (s_acc[i]) begin
        any_acc  = 1'b1;
        sel      = CH_W'(i);
        sel_data = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_user = bus.s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_last = bus.s_axis_tlast[i];
      end
      if (bus.s_axis_tready[i]) rdy_low = CH_W'(i);
    end
  end

  logic oh_err;
  assign oh_err = ($countones(bus.s_axis_tready) > 1);

  // Grant tracking: a multi-beat packet locks the output to its input until tlast.
  mon_state_t      state_q, state_d;
  logic [CH_W-1:0] lock_q, lock_d;
  logic            sw_err;
  logic [CH_W-1:0] sw_ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    sw_err  = 1'b0;
    sw_ch   = '0;
    case (state_q)
      IDLE: begin
        if (any_acc && !sel_last) begin
          state_d = LOCKED;
          lock_d  = sel;
        end
      end
      LOCKED: begin
        for (int j = int'(S_COUNT) - 1; j >= 0; j--) begin
          if (s_acc[j] && (CH_W'(j) != lock_q)) begin
            sw_err = 1'b1;
            sw_ch  = CH_W'(j);
          end
        end
        if (s_acc[lock_q] && bus.s_axis_tlast[lock_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scoreboard: accepted slave beats in order, compared against the master side on pop.
  logic [ENT_W-1:0]        sb_wdata;
  logic [ENT_W-1:0]        sb_head;
  logic                    sb_full;
  logic [$clog2(SB_DEPTH):0] sb_count;
  logic                    sb_empty;
  logic                    pop_ok;
  logic                    data_err;
  logic                    order_err;
  logic                    ovf_err;
  logic [CH_W-1:0]         head_src;
  logic [PAY_W-1:0]        m_vec;

  assign sb_wdata  = {sel, sel_user & user_mask, sel_last, sel_data};
  assign m_vec     = {bus.m_axis_tuser & user_mask, bus.m_axis_tlast, bus.m_axis_tdata};
  assign sb_empty  = (sb_count == '0);
  assign pop_ok    = m_acc & ~sb_empty;
  assign head_src  = sb_head[ENT_W-1 -: CH_W];
  assign data_err  = pop_ok & (sb_head[PAY_W-1:0] != m_vec);
  assign order_err = m_acc & sb_empty;
  assign ovf_err   = any_acc & sb_full & ~pop_ok;

  axis_mon_sb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (SB_DEPTH)
  ) u_sb_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (any_acc),
    .wdata   (sb_wdata),
    .pop     (m_acc),
    .rdata_c (sb_head),
    .full_c  (sb_full),
    .count   (sb_count)
  );

  // Starvation watchdogs: count consecutive stalled cycles per input.
  logic [S_COUNT-1:0] to_hit;
  logic [CH_W-1:0]    to_ch;

  if (TIMEOUT > 0) begin : g_wd
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_ch
      logic [WD_W-1:0] wd_q;
      logic            stall;
      assign stall      = bus.s_axis_tvalid[gi] & ~bus.s_axis_tready[gi];
      assign to_hit[gi] = stall & (wd_q == WD_W'(TIMEOUT - 1));
      always_ff @(posedge clk) begin
        if (rst || !stall)               wd_q <= '0;
        else if (wd_q != WD_W'(TIMEOUT)) wd_q <= wd_q + WD_W'(1);
      end
    end
  end else begin : g_no_wd
    assign to_hit = '0;
  end

  always_comb begin
    to_ch = '0;
    for (int i = int'(S_COUNT) - 1; i >= 0; i--) begin
      if (to_hit[i]) to_ch = CH_W'(i);
    end
  end

  // Saturating packet counters, one per input.
  logic [CNT_WIDTH-1:0] cnt_q [S_COUNT];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(S_COUNT); i++) begin
      if (rst) cnt_q[i] <= '0;
      else if (s_acc[i] && bus.s_axis_tlast[i] && (cnt_q[i] != '1))
        cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
    end
  end

  for (genvar gc = 0; gc < S_COUNT; gc++) begin : g_cnt
    assign pkt_count[gc*CNT_WIDTH +: CNT_WIDTH] = cnt_q[gc];
  end

  // Sticky error latch; err_chan follows the lowest-indexed flag of the first error event.
  logic [ERR_W-1:0] new_err;
  logic [ERR_W-1:0] base_flags;
  logic [ERR_W-1:0] flags_d;
  logic [CH_W-1:0]  base_chan;
  logic [CH_W-1:0]  cand;
  logic [CH_W-1:0]  chan_d;

  always_comb begin
    new_err               = '0;
    new_err[ERR_ONEHOT]   = oh_err;
    new_err[ERR_SWITCH]   = sw_err;
    new_err[ERR_DATA]     = data_err;
    new_err[ERR_ORDER]    = order_err;
    new_err[ERR_OVERFLOW] = ovf_err;
    new_err[ERR_TIMEOUT]  = |to_hit;

    if (oh_err)         cand = rdy_low;
    else if (sw_err)    cand = sw_ch;
    else if (data_err)  cand = head_src;
    else if (order_err) cand = '0;
    else if (ovf_err)   cand = sel;
    else                cand = to_ch;

    base_flags = err_clear ? '0 : err_flags;
    base_chan  = err_clear ? '0 : err_chan;
    flags_d    = base_flags | new_err;
    chan_d     = ((base_flags == '0) && (new_err != '0)) ? cand : base_chan;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flags <= '0;
      err_chan  <= '0;
    end else begin
      err_flags <= flags_d;
      err_chan  <= chan_d;
    end
  end

endmodule

// File: tb/tb_axis_arb_mux_monitor.sv
// Directed and randomized checks of axis_arb_mux_monitor against a queue-based reference model.
module tb_axis_arb_mux_monitor;

  localparam int S_COUNT = 4;
  localparam int DW      = 8;
  localparam int DEPTH   = 8;
  localparam int TMO     = 32;
  localparam int CMAX    = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clear;
  logic [5:0]  err_flags;
  logic [1:0]  err_chan;
  logic [63:0] pkt_count;

  always #5 clk = ~clk;

  axis_arb_mux_monitor_if #(.S_COUNT(S_COUNT), .DATA_WIDTH(DW), .USER_WIDTH(1)) bus ();

  axis_arb_mux_monitor #(
    .S_COUNT(S_COUNT), .DATA_WIDTH(DW), .USER_ENABLE(1), .USER_WIDTH(1),
    .SB_DEPTH(DEPTH), .TIMEOUT(TMO), .CNT_WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_clear (err_clear),
    .err_flags (err_flags),
    .err_chan  (err_chan),
    .pkt_count (pkt_count)
  );

  typedef struct packed {
    logic [1:0] src;
    logic       user;
    logic       last;
    logic [7:0] data;
  } beat_t;

  // Reference model state
  beat_t      q[$];
  bit         locked;
  int         lock_ch;
  int         wd[S_COUNT];
  int         pk[S_COUNT];
  logic [5:0] exp_flags;
  int         exp_chan;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit acc(input int i);
    return bus.s_axis_tvalid[i] & bus.s_axis_tready[i];
  endfunction

  function automatic beat_t beat_of(input int i);
    beat_t b;
    b.src  = 2'(i);
    b.user = bus.s_axis_tuser[i];
    b.last = bus.s_axis_tlast[i];
    b.data = bus.s_axis_tdata[i*DW +: DW];
    return b;
  endfunction

  // The first flag raised in a cycle (lowest bit order) names the channel.
  task automatic raise(inout logic [5:0] nf, inout int cand, input int bitn, input int ch);
    if (nf == 6'd0) cand = ch;
    nf[bitn] = 1'b1;
  endtask

  task automatic model_step();
    logic [5:0] nf;
    int cand, sel, pre, lowr;
    bit popped;
    beat_t e;
    if (rst) begin
      q.delete();
      locked = 0; lock_ch = 0;
      for (int i = 0; i < S_COUNT; i++) begin wd[i] = 0; pk[i] = 0; end
      exp_flags = 6'd0; exp_chan = 0;
      return;
    end
    nf = 6'd0; cand = 0; sel = -1; lowr = -1; popped = 0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (acc(i) && sel < 0) sel = i;
      if (bus.s_axis_tready[i] && lowr < 0) lowr = i;
    end
    if ($countones(bus.s_axis_tready) > 1) raise(nf, cand, 0, lowr);
    if (locked) begin
      for (int j = 0; j < S_COUNT; j++)
        if (acc(j) && j != lock_ch && !nf[1]) raise(nf, cand, 1, j);
      if (acc(lock_ch) && bus.s_axis_tlast[lock_ch]) locked = 0;
    end else if (sel >= 0 && !bus.s_axis_tlast[sel]) begin
      locked = 1; lock_ch = sel;
    end
    pre = q.size();
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (pre == 0) raise(nf, cand, 3, 0);
      else begin
        e = q.pop_front();
        popped = 1;
        if (e.data !== bus.m_axis_tdata || e.last !== bus.m_axis_tlast || e.user !== bus.m_axis_tuser[0])
          raise(nf, cand, 2, int'(e.src));
      end
    end
    if (sel >= 0) begin
      if (pre == DEPTH && !popped) raise(nf, cand, 4, sel);
      else q.push_back(beat_of(sel));
    end
    for (int i = 0; i < S_COUNT; i++) begin
      if (bus.s_axis_tvalid[i] && !bus.s_axis_tready[i]) begin
        if (wd[i] == TMO - 1) raise(nf, cand, 5, i);
        if (wd[i] < TMO) wd[i]++;
      end else wd[i] = 0;
      if (acc(i) && bus.s_axis_tlast[i] && pk[i] < CMAX) pk[i]++;
    end
    if (err_clear) begin exp_flags = 6'd0; exp_chan = 0; end
    if (exp_flags == 6'd0 && nf != 6'd0) exp_chan = cand;
    exp_flags = exp_flags | nf;
  endtask

  function automatic logic [63:0] exp_pkts();
    logic [63:0] v;
    for (int i = 0; i < S_COUNT; i++) v[i*16 +: 16] = 16'(pk[i]);
    return v;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("err_flags", 64'(err_flags), 64'(exp_flags));
    chk("err_chan", 64'(err_chan), 64'(exp_chan));
    chk("pkt_count", pkt_count, exp_pkts());
    err_clear = 1'b0;
  endtask

  task automatic idle();
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tready = '0;
    bus.s_axis_tlast  = '0;
    bus.s_axis_tuser  = '0;
    bus.m_axis_tdata  = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b0;
    bus.m_axis_tlast  = 1'b0;
    bus.m_axis_tuser  = '0;
  endtask

  task automatic s_beat(input int i, input logic [7:0] d, input logic last);
    bus.s_axis_tvalid = 4'(1 << i);
    bus.s_axis_tready = 4'(1 << i);
    bus.s_axis_tlast  = last ? 4'(1 << i) : 4'd0;
    bus.s_axis_tuser  = d[0] ? 4'(1 << i) : 4'd0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tdata[i*DW +: DW] = d;
  endtask

  task automatic m_beat(input logic [7:0] d, input logic last, input logic user);
    bus.m_axis_tvalid = 1'b1;
    bus.m_axis_tready = 1'b1;
    bus.m_axis_tdata  = d;
    bus.m_axis_tlast  = last;
    bus.m_axis_tuser  = user;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no end expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int r;
    err_clear = 1'b0;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("reset_flags", 64'(err_flags), 64'd0);
    chk("reset_chan", 64'(err_chan), 64'd0);
    chk("reset_pkts", pkt_count, 64'd0);

    // Three-beat packet on input 2, forwarded two cycles later
    s_beat(2, 8'hA1, 1'b0); tick();
    s_beat(2, 8'hA2, 1'b0); tick();
    s_beat(2, 8'hA3, 1'b1); m_beat(8'hA1, 1'b0, 1'b1); tick();
    idle(); m_beat(8'hA2, 1'b0, 1'b0); tick();
    idle(); m_beat(8'hA3, 1'b1, 1'b1); tick();
    idle(); tick();
    chk("t1_no_err", 64'(err_flags), 64'd0);
    chk("t1_pkt2", 64'(pkt_count[47:32]), 64'd1);

    // Wrong data forwarded
    do_reset();
    s_beat(2, 8'hA1, 1'b1); tick();
    idle(); m_beat(8'hA2, 1'b1, 1'b0); tick();
    chk("t2_data_flag", 64'(err_flags[2]), 64'd1);
    chk("t2_chan", 64'(err_chan), 64'd2);

    // Handshake on another input while locked
    do_reset();
    s_beat(0, 8'h10, 1'b0); tick();
    s_beat(1, 8'h20, 1'b0); tick();
    chk("t3_switch_flag", 64'(err_flags[1]), 64'd1);
    chk("t3_chan", 64'(err_chan), 64'd1);

    // Two readies, then clear
    do_reset();
    idle(); bus.s_axis_tready = 4'b0011; tick();
    chk("t4_onehot_flag", 64'(err_flags[0]), 64'd1);
    chk("t4_chan", 64'(err_chan), 64'd0);
    idle(); err_clear = 1'b1; tick();
    chk("t4_cleared", 64'(err_flags), 64'd0);

    // Starvation watchdog boundary
    do_reset();
    idle(); bus.s_axis_tvalid = 4'b1000;
    repeat (31) tick();
    chk("t5_31_no_flag", 64'(err_flags), 64'd0);
    bus.s_axis_tvalid = 4'b0000; tick();
    bus.s_axis_tvalid = 4'b1000;
    repeat (31) tick();
    chk("t5_31_again", 64'(err_flags[5]), 64'd0);
    tick();
    chk("t5_timeout_flag", 64'(err_flags[5]), 64'd1);
    chk("t5_chan", 64'(err_chan), 64'd3);

    // Overflow on the ninth stalled beat
    do_reset();
    for (int k = 0; k < 8; k++) begin s_beat(0, 8'(k), 1'b1); tick(); end
    chk("t6_full_no_err", 64'(err_flags), 64'd0);
    s_beat(0, 8'h08, 1'b1); tick();
    chk("t6_overflow_flag", 64'(err_flags[4]), 64'd1);
    chk("t6_pkt0", 64'(pkt_count[15:0]), 64'd9);

    // Pop from an empty scoreboard
    do_reset();
    idle(); m_beat(8'h00, 1'b1, 1'b0); tick();
    chk("t6_order_flag", 64'(err_flags[3]), 64'd1);

    // Reset in the middle of a packet
    do_reset();
    s_beat(1, 8'h55, 1'b0); tick();
    rst = 1'b1; idle(); tick();
    chk("t6_rst_flags", 64'(err_flags), 64'd0);
    chk("t6_rst_pkts", pkt_count, 64'd0);
    rst = 1'b0;
    s_beat(2, 8'h66, 1'b0); tick();
    chk("t6_fresh_packet", 64'(err_flags), 64'd0);

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < S_COUNT; i++) begin
        bus.s_axis_tvalid[i] = ($urandom_range(0, 3) != 0);
        bus.s_axis_tlast[i]  = ($urandom_range(0, 3) == 0);
        bus.s_axis_tuser[i]  = 1'($urandom);
        bus.s_axis_tdata[i*DW +: DW] = 8'($urandom);
      end
      r = $urandom_range(0, 99);
      if (r < 80)      bus.s_axis_tready = 4'(1 << $urandom_range(0, 3));
      else if (r < 92) bus.s_axis_tready = 4'd0;
      else             bus.s_axis_tready = 4'($urandom);
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        bus.m_axis_tvalid = 1'b1;
        bus.m_axis_tdata  = q[0].data ^ (($urandom_range(0, 19) == 0) ? 8'h01 : 8'h00);
        bus.m_axis_tlast  = q[0].last;
        bus.m_axis_tuser  = q[0].user;
      end else begin
        bus.m_axis_tvalid = ($urandom_range(0, 19) == 0);
        bus.m_axis_tdata  = 8'($urandom);
        bus.m_axis_tlast  = 1'($urandom);
        bus.m_axis_tuser  = 1'($urandom);
      end
      bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      err_clear = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
